// File: rtl/alu_seq.sv
// alu_seq: handshaked, registered ALU for the decode/issue -> writeback path.
// Single-cycle ops (ADD..SRL, illegal) produce a result one cycle after
// acceptance; MUL/DIVU/REMU iterate one bit per cycle for WIDTH cycles.
// Only one operation is in flight at a time.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   request handshake for A, B, funct
//   A, B, funct         operands and opcode (B[SHW-1:0] is the shift amount)
//   out_valid/out_ready result handshake for out and the flags
//   out                 result
//   flagZ/flagS         zero / sign of out
//   flagC/flagV         carry (ADD) or no-borrow (SUB) / signed overflow
//   err                 illegal opcode, or DIVU/REMU with B == 0
//   busy                FSM is not IDLE
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds its payload stable while valid && !ready;
// the result side holds out/flags/err stable while out_valid && !out_ready.
// in_ready is also high in DONE when out_ready is high, so a new request can
// be accepted on the same edge the previous result is consumed.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       funct,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             flagZ,
  output logic             flagS,
  output logic             flagC,
  output logic             flagV,
  output logic             err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOT  = 4'b0101;
  localparam logic [3:0] OP_SLA  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_MUL  = 4'b1001;
  localparam logic [3:0] OP_DIVU = 4'b1010;
  localparam logic [3:0] OP_REMU = 4'b1011;

  // FSM state is kept in a named enum so checkers can bind to it directly.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic accept;
  logic iter_op;

  // Captured operands and iteration state.
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [3:0]       op_r;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;  // running product (MUL) or partial remainder (DIV/REM)
  logic [WIDTH-1:0] q;    // multiplier bits (MUL) or dividend/quotient bits (DIV/REM)

  assign accept  = in_valid && in_ready;
  assign iter_op = (funct == OP_MUL) || (funct == OP_DIVU) || (funct == OP_REMU);

  // ---------------------------------------------------------------------
  // Single-cycle datapath, evaluated directly on the request inputs.
  // ---------------------------------------------------------------------
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   add_full;
  logic [WIDTH-1:0] sub_res;
  logic [WIDTH-1:0] sc_res;
  logic             sc_c;
  logic             sc_v;
  logic             sc_err;

  assign shamt    = B[SHW-1:0];
  assign add_full = {1'b0, A} + {1'b0, B};
  assign sub_res  = A - B;

  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    sc_err = 1'b0;
    case (funct)
      OP_ADD: begin
        sc_res = add_full[WIDTH-1:0];
        sc_c   = add_full[WIDTH];
        sc_v   = (A[WIDTH-1] == B[WIDTH-1]) && (add_full[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = sub_res;
        sc_c   = (A >= B);
        sc_v   = (A[WIDTH-1] != B[WIDTH-1]) && (sub_res[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:  sc_res = A & B;
      OP_OR:   sc_res = A | B;
      OP_XOR:  sc_res = A ^ B;
      OP_NOT:  sc_res = ~A;
      OP_SLA:  sc_res = A << shamt;
      OP_SRA:  sc_res = $signed(A) >>> shamt;
      OP_SRL:  sc_res = A >> shamt;
      OP_MUL, OP_DIVU, OP_REMU: sc_res = '0;  // handled by the iterative path
      default: sc_err = 1'b1;                 // illegal opcode: out stays 0
    endcase
  end

  // ---------------------------------------------------------------------
  // Iterative step: MSB-first shift-add for MUL, restoring shift-subtract
  // for DIVU/REMU. With B == 0 the restoring divider naturally yields an
  // all-ones quotient and a remainder equal to A, so no special case needed.
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] mul_nx;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_nx;
  logic [WIDTH-1:0] div_q_nx;
  logic [WIDTH-1:0] fin_res;

  assign mul_nx     = {acc[WIDTH-2:0], 1'b0} + (q[WIDTH-1] ? a_r : '0);
  assign div_trial  = {acc, q[WIDTH-1]};
  assign div_diff   = div_trial - {1'b0, b_r};
  assign div_ge     = (div_trial >= {1'b0, b_r});
  // When the trial is below the divisor its top bit is necessarily 0.
  assign div_rem_nx = div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];
  assign div_q_nx   = {q[WIDTH-2:0], div_ge};

  always_comb begin
    case (op_r)
      OP_MUL:  fin_res = mul_nx;
      OP_DIVU: fin_res = div_q_nx;
      default: fin_res = div_rem_nx;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) state_nx = iter_op ? CALC : DONE;
      end
      CALC: begin
        if (cnt == CW'(1)) state_nx = DONE;
      end
      DONE: begin
        if (accept)         state_nx = iter_op ? CALC : DONE;
        else if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_r   <= '0;
      b_r   <= '0;
      op_r  <= '0;
      cnt   <= '0;
      acc   <= '0;
      q     <= '0;
      out   <= '0;
      flagZ <= 1'b0;
      flagS <= 1'b0;
      flagC <= 1'b0;
      flagV <= 1'b0;
      err   <= 1'b0;
    end else if (accept) begin
      a_r  <= A;
      b_r  <= B;
      op_r <= funct;
      cnt  <= CW'(WIDTH);
      acc  <= '0;
      q    <= (funct == OP_MUL) ? B : A;
      if (!iter_op) begin
        out   <= sc_res;
        flagZ <= (sc_res == '0);
        flagS <= sc_res[WIDTH-1];
        flagC <= sc_c;
        flagV <= sc_v;
        err   <= sc_err;
      end
    end else if (state == CALC) begin
      if (op_r == OP_MUL) begin
        acc <= mul_nx;
        q   <= {q[WIDTH-2:0], 1'b0};
      end else begin
        acc <= div_rem_nx;
        q   <= div_q_nx;
      end
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        out   <= fin_res;
        flagZ <= (fin_res == '0);
        flagS <= fin_res[WIDTH-1];
        flagC <= 1'b0;
        flagV <= 1'b0;
        err   <= (op_r != OP_MUL) && (b_r == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq: a 32-bit and an 8-bit instance share clock and
// reset; the variable use8 selects which one the driver talks to.
module tb_alu_seq;

  logic clk;
  logic rst;
  logic iv;
  logic out_ready;
  logic use8;
  logic [3:0]  fn;
  logic [63:0] av;
  logic [63:0] bv;

  int errors;
  int checks;

  logic [63:0] exp_q[$];

  // 32-bit instance
  logic        iv32, ir32, ov32, z32, s32, c32, v32, e32, busy32;
  logic [31:0] o32;
  // 8-bit instance
  logic        iv8, ir8, ov8, z8, s8, c8, v8, e8, busy8;
  logic [7:0]  o8;

  // Selected-instance view
  logic        v_ir, v_ov, v_z, v_s, v_c, v_v, v_err, v_busy;
  logic [63:0] v_out;

  alu_seq #(.WIDTH(32)) dut32 (
    .clock(clk), .reset(rst), .in_valid(iv32), .in_ready(ir32),
    .A(av[31:0]), .B(bv[31:0]), .funct(fn),
    .out_valid(ov32), .out_ready(out_ready), .out(o32),
    .flagZ(z32), .flagS(s32), .flagC(c32), .flagV(v32), .err(e32), .busy(busy32)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clock(clk), .reset(rst), .in_valid(iv8), .in_ready(ir8),
    .A(av[7:0]), .B(bv[7:0]), .funct(fn),
    .out_valid(ov8), .out_ready(out_ready), .out(o8),
    .flagZ(z8), .flagS(s8), .flagC(c8), .flagV(v8), .err(e8), .busy(busy8)
  );

  always_comb begin
    iv32   = iv && !use8;
    iv8    = iv && use8;
    v_ir   = use8 ? ir8 : ir32;
    v_ov   = use8 ? ov8 : ov32;
    v_z    = use8 ? z8 : z32;
    v_s    = use8 ? s8 : s32;
    v_c    = use8 ? c8 : c32;
    v_v    = use8 ? v8 : v32;
    v_err  = use8 ? e8 : e32;
    v_busy = use8 ? busy8 : busy32;
    v_out  = use8 ? {56'd0, o8} : {32'd0, o32};
  end

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------
  // Reference model: plain arithmetic on 64-bit values, masked to w bits.
  // Result bundle is {out[63:0], Z, S, C, V, err}.
  // ---------------------------------------------------------------------
  task automatic model(input int w, input logic [3:0] f, input logic [63:0] a_in,
                       input logic [63:0] b_in, output logic [68:0] bundle);
    logic [63:0] mask, a, b, r, full;
    logic signed [63:0] sx;
    logic c, v, e;
    int sh;
    mask = (64'd1 << w) - 64'd1;
    a = a_in & mask;
    b = b_in & mask;
    sh = int'(b & 64'(w - 1));  // w is a power of two in this bench
    r = 0; c = 0; v = 0; e = 0;
    case (f)
      4'd0: begin
        full = a + b;
        r = full & mask;
        c = full[w];
        v = (a[w-1] == b[w-1]) && (r[w-1] != a[w-1]);
      end
      4'd1: begin
        r = (a - b) & mask;
        c = (a >= b);
        v = (a[w-1] != b[w-1]) && (r[w-1] != a[w-1]);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a & mask;
      4'd6: r = (a << sh) & mask;
      4'd7: begin
        sx = a[w-1] ? $signed(a | ~mask) : $signed(a);
        r = (sx >>> sh) & mask;
      end
      4'd8: r = a >> sh;
      4'd9: r = (a * b) & mask;
      4'd10: begin
        if (b == 0) begin r = mask; e = 1; end
        else r = a / b;
      end
      4'd11: begin
        if (b == 0) begin r = a; e = 1; end
        else r = a % b;
      end
      default: begin r = 0; e = 1; end
    endcase
    bundle = {r, (r == 0), r[w-1], c, v, e};
  endtask

  function automatic int exp_lat(input int w, input logic [3:0] f);
    return (f >= 4'd9 && f <= 4'd11) ? w + 1 : 1;
  endfunction

  // ---------------------------------------------------------------------
  // Driver: issue one request, wait for its result, return what was seen.
  // Returns at the falling edge where out_valid was first observed high.
  // ---------------------------------------------------------------------
  task automatic issue(input logic [3:0] f, input logic [63:0] a, input logic [63:0] b,
                       output int lat, output logic [68:0] obs, output bit calc_bad);
    int guard;
    @(posedge clk); #1;
    fn = f; av = a; bv = b; iv = 1'b1;
    guard = 0;
    @(negedge clk);
    while (v_ir !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk); #1;
    iv = 1'b0;
    lat = 1;
    calc_bad = 0;
    @(negedge clk);
    while (v_ov !== 1'b1 && lat < 200) begin
      if (v_busy !== 1'b1 || v_ir !== 1'b0) calc_bad = 1;
      @(negedge clk);
      lat++;
    end
    obs = {v_out, v_z, v_s, v_c, v_v, v_err};
  endtask

  // ---------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------
  task automatic test_reset();
    logic [68:0] obs;
    rst = 1'b1; iv = 1'b0; out_ready = 1'b1; use8 = 1'b0;
    fn = 0; av = 0; bv = 0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      use8 = (k == 1);
      #0;
      obs = {v_out, v_z, v_s, v_c, v_v, v_err};
      checks++;
      if (obs !== 69'd0) begin
        errors++;
        $display("FAIL reset_outputs w%0d: got %h expected 0", k ? 8 : 32, obs);
      end
      checks++;
      if ({v_ov, v_busy, v_ir} !== 3'b001) begin
        errors++;
        $display("FAIL reset_ctrl w%0d: got ov/busy/ir=%b expected 001", k ? 8 : 32, {v_ov, v_busy, v_ir});
      end
    end
    use8 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0]  tf[3];
    logic [63:0] ta[3], tb[3];
    logic [68:0] e;
    logic [63:0] want;
    tf = '{4'd0, 4'd4, 4'd6};
    ta = '{64'd5, 64'd12, 64'd16};
    tb = '{64'd7, 64'd7, 64'd1};
    use8 = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      fn = tf[i]; av = ta[i]; bv = tb[i]; iv = 1'b1;
      model(32, tf[i], ta[i], tb[i], e);
      exp_q.push_back(e[68:5]);
      @(negedge clk);
      checks++;
      if (v_ir !== 1'b1) begin
        errors++;
        $display("FAIL b2b_in_ready op%0d: got %b expected 1", i, v_ir);
      end
      if (i > 0) begin
        want = exp_q.pop_front();
        checks++;
        if (v_ov !== 1'b1 || v_out !== want) begin
          errors++;
          $display("FAIL b2b_result op%0d: got valid=%b out=%h expected valid=1 out=%h", i - 1, v_ov, v_out, want);
        end
      end
      @(posedge clk); #1;
    end
    iv = 1'b0;
    @(negedge clk);
    want = exp_q.pop_front();
    checks++;
    if (v_ov !== 1'b1 || v_out !== want || want !== 64'd32) begin
      errors++;
      $display("FAIL b2b_result op2: got valid=%b out=%h expected valid=1 out=%h", v_ov, v_out, 64'd32);
    end
  endtask

  // Runs a table of single requests against the model, including latency.
  task automatic run_table(input string name, input int w, input logic [3:0] f[],
                           input logic [63:0] a[], input logic [63:0] b[]);
    logic [68:0] obs, e;
    int lat;
    bit cb;
    use8 = (w == 8);
    for (int i = 0; i < f.size(); i++) begin
      model(w, f[i], a[i], b[i], e);
      issue(f[i], a[i], b[i], lat, obs, cb);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL %s[%0d] f=%h: got %h expected %h", name, i, f[i], obs, e);
      end
      checks++;
      if (lat != exp_lat(w, f[i]) || cb) begin
        errors++;
        $display("FAIL %s_latency[%0d]: got lat=%0d calc_bad=%0d expected lat=%0d calc_bad=0",
                 name, i, lat, cb, exp_lat(w, f[i]));
      end
    end
    use8 = 1'b0;
  endtask

  task automatic test_flags();
    run_table("flags", 32, '{4'd1, 4'd0, 4'd4},
              '{64'hFFFF_FFF6, 64'h7FFF_FFFF, 64'd15}, '{64'd5, 64'd1, 64'd15});
  endtask

  task automatic test_shifts();
    run_table("shifts", 32, '{4'd7, 4'd8, 4'd6, 4'd6},
              '{64'hFFFF_FFF4, 64'hAAAA_AAAA, 64'd1, 64'h1234_5678},
              '{64'd1, 64'd1, 64'd33, 64'h0000_0100});
  endtask

  task automatic test_iterative();
    run_table("iter", 8, '{4'd9, 4'd10, 4'd11, 4'd10, 4'd11},
              '{64'd13, 64'd200, 64'd200, 64'd5, 64'd5}, '{64'd11, 64'd7, 64'd7, 64'd0, 64'd0});
  endtask

  task automatic test_illegal();
    run_table("illegal", 32, '{4'd13, 4'd12, 4'd15},
              '{64'hDEAD_BEEF, 64'd1, 64'hFFFF_FFFF}, '{64'd3, 64'd1, 64'hFFFF_FFFF});
  endtask

  task automatic test_hold();
    logic [68:0] obs, e, e2;
    int lat;
    bit cb;
    use8 = 1'b0;
    model(32, 4'd2, 64'hF0F0_1234, 64'h8F00_FF0F, e);
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(4'd2, 64'hF0F0_1234, 64'h8F00_FF0F, lat, obs, cb);
    checks++;
    if (obs !== e || lat != 1) begin
      errors++;
      $display("FAIL hold_first: got %h lat=%0d expected %h lat=1", obs, lat, e);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      obs = {v_out, v_z, v_s, v_c, v_v, v_err};
      checks++;
      if (obs !== e || v_ov !== 1'b1 || v_ir !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable[%0d]: got %h valid=%b ready=%b expected %h valid=1 ready=0",
                 k, obs, v_ov, v_ir, e);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    fn = 4'd3; av = 64'h0000_00F0; bv = 64'h0000_0F00; iv = 1'b1;
    model(32, 4'd3, av, bv, e2);
    @(negedge clk);
    checks++;
    if (v_ir !== 1'b1) begin
      errors++;
      $display("FAIL hold_release_ready: got %b expected 1", v_ir);
    end
    @(posedge clk); #1;
    iv = 1'b0;
    @(negedge clk);
    obs = {v_out, v_z, v_s, v_c, v_v, v_err};
    checks++;
    if (v_ov !== 1'b1 || obs !== e2) begin
      errors++;
      $display("FAIL hold_next_result: got valid=%b %h expected valid=1 %h", v_ov, obs, e2);
    end
  endtask

  task automatic test_reset_mid_calc();
    logic [68:0] obs, e;
    int lat;
    bit cb;
    bit saw_valid;
    use8 = 1'b0; out_ready = 1'b1;
    // Leave non-zero out/flags behind so the reset clearing is observable.
    issue(4'd0, 64'h7FFF_FFFF, 64'd1, lat, obs, cb);
    @(posedge clk); #1;
    fn = 4'd9; av = 64'd123456; bv = 64'd654321; iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    obs = {v_out, v_z, v_s, v_c, v_v, v_err};
    checks++;
    if (obs !== 69'd0 || v_ov !== 1'b0 || v_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_calc_outputs: got %h valid=%b busy=%b expected 0", obs, v_ov, v_busy);
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (v_ir !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_after: got %b expected 1", v_ir);
    end
    saw_valid = 0;
    for (int k = 0; k < 40; k++) begin
      if (v_ov === 1'b1) saw_valid = 1;
      @(negedge clk);
    end
    checks++;
    if (saw_valid) begin
      errors++;
      $display("FAIL reset_aborted_op: got out_valid=1 expected 0");
    end
    model(32, 4'd0, 64'd1, 64'd2, e);
    issue(4'd0, 64'd1, 64'd2, lat, obs, cb);
    checks++;
    if (obs !== e || lat != 1) begin
      errors++;
      $display("FAIL reset_first_op: got %h lat=%0d expected %h lat=1", obs, lat, e);
    end
  endtask

  task automatic test_random(input int w, input int n);
    logic [68:0] obs, e;
    logic [63:0] a, b, mask;
    logic [3:0]  f;
    int lat;
    bit cb;
    use8 = (w == 8);
    mask = (64'd1 << w) - 64'd1;
    for (int i = 0; i < n; i++) begin
      f = 4'($urandom_range(0, 15));
      a = {32'd0, $urandom()} & mask;
      case ($urandom_range(0, 5))
        0:       b = 64'd0;
        1:       b = 64'($urandom_range(1, 7));
        default: b = {32'd0, $urandom()} & mask;
      endcase
      model(w, f, a, b, e);
      exp_q.push_back({f, e[68:5]} );
      issue(f, a, b, lat, obs, cb);
      checks++;
      if (obs !== e || lat != exp_lat(w, f) || cb) begin
        errors++;
        $display("FAIL random_w%0d[%0d] f=%h a=%h b=%h: got %h lat=%0d expected %h lat=%0d",
                 w, i, f, a, b, obs, lat, e, exp_lat(w, f));
      end
      void'(exp_q.pop_front());
    end
    use8 = 1'b0;
  endtask

  // ---------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------
  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_back_to_back();
    test_flags();
    test_shifts();
    test_iterative();
    test_hold();
    test_illegal();
    test_reset_mid_calc();
    test_random(8, 40);
    test_random(32, 60);
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the combinational 4-bit-funct ALU.
- Same op encoding for the single-cycle ops, with registered results.
- Adds iterative unsigned MUL/DIVU/REMU, carry and overflow flags, an illegal-op error, and valid/ready flow control on both sides.
- Sits between the decode/issue stage and writeback. One operation in flight at a time.

Parameters:
- WIDTH, 32, operand and result width in bits; must be at least 4.
- SHW, $clog2(WIDTH), number of low bits of B used as shift amount; derived, do not override.

Ports:
- clock  in  1  system clock; rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  request present on A/B/funct.
- in_ready  out  1  block can accept a request this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B; low SHW bits are the shift amount for shifts.
- funct  in  4  opcode.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts the result.
- out  out  WIDTH  result.
- flagZ  out  1  out == 0.
- flagS  out  1  out[WIDTH-1].
- flagC  out  1  carry out (ADD) or no-borrow (SUB); 0 for all other ops.
- flagV  out  1  signed overflow (ADD/SUB); 0 for all other ops.
- err  out  1  illegal funct, or DIVU/REMU with B == 0.
- busy  out  1  state != IDLE.

Behaviour:
- Opcodes:
  - 0000 ADD: A+B.
  - 0001 SUB: A-B.
  - 0010 AND.
  - 0011 OR.
  - 0100 XOR.
  - 0101 NOT: ~A.
  - 0110 SLA: A<<B[SHW-1:0].
  - 0111 SRA: arithmetic right shift, sign-filled.
  - 1000 SRL: logical right shift, zero-filled.
  - 1001 MUL: low WIDTH bits of unsigned A*B.
  - 1010 DIVU: unsigned A/B.
  - 1011 REMU: unsigned A%B.
  - 1100-1111: illegal.
- Operands and funct are captured into internal registers at acceptance. Input changes after acceptance have no effect.
- FSM states are IDLE, CALC, DONE. Reset state is IDLE.
- Acceptance occurs when in_valid && in_ready.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This allows back-to-back issue in the same cycle the previous result is consumed.
- On acceptance of opcodes 0000-1000 or an illegal opcode: result is computed and registered; next state is DONE. out_valid rises on the edge of acceptance, i.e. it is visible in the cycle after the accept cycle (latency 1).
- On acceptance of MUL/DIVU/REMU: next state is CALC, with an iteration counter loaded to WIDTH.
  - Each CALC cycle performs one shift-add (MUL) or one restoring shift-subtract (DIV/REM) step, then decrements the counter.
  - When the counter reaches 1, the final step is written and the next state is DONE.
  - out_valid is visible WIDTH+1 cycles after the accept cycle.
- In DONE:
  - out, flags and err hold stable while out_valid && !out_ready.
  - out_ready=1 with no new accept: next state is IDLE and out_valid drops.
  - out_ready=1 with a simultaneous accept: the new op proceeds exactly as if accepted from IDLE.
- Outputs outside DONE: out_valid=0. out and the flags hold their last values; consumers must ignore them.
- Flags:
  - flagZ and flagS are computed from the final registered out for every op, including error cases.
  - ADD: flagC = carry out of bit WIDTH-1; flagV = (A and B signs equal) && (result sign differs).
  - SUB: flagC = (A >= B unsigned); flagV = (A and B signs differ) && (result sign != A sign).
- Shift amounts: shifts use only B[SHW-1:0]; upper bits of B are ignored. A shift amount of 0 returns A.
- Divide by zero: CALC is still traversed for full latency.
  - DIVU returns all ones; REMU returns A.
  - err=1.
- Illegal funct: out=0, flagZ=1, flagS=flagC=flagV=0, err=1, latency 1.
- Reset, asserted at any time including mid-CALC:
  - Immediately forces IDLE and aborts any in-flight op; the result is lost.
  - out=0, out_valid=0, busy=0, err=0, and all flags 0.
  - in_ready reads 1 from the first cycle after reset deasserts.

Test Plan:
- WIDTH=32, back-to-back with out_ready=1: ADD 5,7 -> 12; XOR 12,7 -> 11; SLA 16,1 -> 32. Each out_valid appears 1 cycle after its accept, and in_ready stays 1 throughout.
- WIDTH=32, SUB A=-10, B=5 -> 0xFFFFFFF1, flagS=1, flagC=1, flagV=0. Then ADD 0x7FFFFFFF+1 -> 0x80000000, flagV=1, flagC=0. Then XOR 15,15 -> 0, flagZ=1.
- WIDTH=32, SRA 0xFFFFFFF4 by 1 -> 0xFFFFFFFA; SRL 0xAAAAAAAA by 1 -> 0x55555555; SLA 1 by B=33 (amount 1) -> 2.
- WIDTH=8: MUL 13*11 -> 143 (0x8F), out_valid 9 cycles after accept, busy=1 meanwhile, in_ready=0 during CALC. DIVU 200/7 -> 28; REMU 200/7 -> 4; DIVU 5/0 -> 0xFF, err=1; REMU 5/0 -> 5, err=1.
- WIDTH=32, out_ready held 0 for 5 cycles after an AND result: out, flags and out_valid stay stable and in_ready=0. On release, a new request in the same cycle is accepted, and its result appears the next cycle.
- funct=1101 -> out=0, flagZ=1, err=1. Reset asserted mid-MUL (CALC cycle 10): out_valid never rises for the aborted op, and all outputs are 0 during reset. First op after reset (ADD 1,2 -> 3) completes normally.
